// File: rtl/udma_l2_rr_arbiter.sv
// Round-robin arbiter sharing one uDMA L2 port (req/gnt/rvalid, in-order
// responses) among N_REQ requesters. The address phase is locked until it is
// granted, and the ID of every granted transaction is queued so that each
// response is routed back to the requester that issued it.
module udma_l2_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_i,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ-1:0]               wen_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]    wdata_i,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]  be_i,
    output logic [N_REQ-1:0]               gnt_o,
    output logic [N_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           l2_req_o,
    output logic                           l2_wen_o,
    output logic [ADDR_WIDTH-1:0]          l2_addr_o,
    output logic [DATA_WIDTH-1:0]          l2_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        l2_be_o,
    input  logic                           l2_gnt_i,
    input  logic                           l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          l2_rdata_i,
    output logic [$clog2(MAX_OUTST):0]     outst_o,
    output logic                           err_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int FA_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   lidx;
    logic               lock;
    logic [IDX_W-1:0]   win;
    logic               any_req;
    logic               l2_req;
    logic               grant;
    logic               pop;
    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   id_fifo [MAX_OUTST];
    logic [FA_W-1:0]    wr_ptr;
    logic [FA_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [2*N_REQ-1:0] req_dbl;
    logic [IDX_W:0]     off;
    logic [IDX_W:0]     sum;

    // Next round-robin pointer: one past the granted requester, wrapping.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // FIFO pointer increment wrapping at the configured depth.
    function automatic logic [FA_W-1:0] next_fa(input logic [FA_W-1:0] p);
        return (p == FA_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Winner: the locked index, or the first request at or after ptr.
    always_comb begin
        req_dbl = {req_i, req_i} >> ptr;
        off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_dbl[i]) off = (IDX_W+1)'(i);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        if (lock) begin
            win     = lidx;
            any_req = req_i[lidx];
        end else begin
            win     = sum[IDX_W-1:0];
            any_req = |req_i;
        end
    end

    assign l2_req = any_req && (cnt < CNT_W'(MAX_OUTST));
    assign grant  = l2_req && l2_gnt_i;
    assign pop    = l2_rvalid_i && (cnt != '0);
    assign head   = id_fifo[rd_ptr];

    // Output mux; every output is forced to zero while reset is held.
    always_comb begin
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        l2_req_o   = 1'b0;
        l2_wen_o   = 1'b0;
        l2_addr_o  = '0;
        l2_wdata_o = '0;
        l2_be_o    = '0;
        outst_o    = '0;
        err_o      = 1'b0;
        if (!sys_rst_i) begin
            l2_req_o   = l2_req;
            l2_wen_o   = wen_i[win];
            l2_addr_o  = addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
            l2_wdata_o = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
            l2_be_o    = be_i[win*BE_W +: BE_W];
            if (grant) gnt_o[win] = 1'b1;
            if (pop) rvalid_o[head] = 1'b1;
            rdata_o    = l2_rdata_i;
            outst_o    = cnt;
            err_o      = l2_rvalid_i && (cnt == '0);
        end
    end

    // Control state: pointer, lock, FIFO pointers and outstanding count.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ptr    <= '0;
            lock   <= 1'b0;
            lidx   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (grant) begin
                lock <= 1'b0;
                ptr  <= next_idx(win);
            end else if (l2_req) begin
                lock <= 1'b1;
                lidx <= win;
            end
            if (grant) wr_ptr <= next_fa(wr_ptr);
            if (pop) rd_ptr <= next_fa(rd_ptr);
            case ({grant, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ID storage; only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge sys_clk_i) begin
        if (grant) id_fifo[wr_ptr] <= win;
    end

endmodule

// File: tb/tb_udma_l2_rr_arbiter.sv
// Directed bench for udma_l2_rr_arbiter: a fairness vector table plus
// hand-written sequences for lock, full, push/pop, spurious and reset cases.
module tb_udma_l2_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, wen;
    logic [127:0] addr, wdata;
    logic [15:0]  be;
    logic [3:0]   gnt_o, rvalid_o;
    logic [31:0]  rdata_o;
    logic         l2_req_o, l2_wen_o;
    logic [31:0]  l2_addr_o, l2_wdata_o;
    logic [3:0]   l2_be_o;
    logic         l2_gnt, l2_rv;
    logic [31:0]  l2_rdata;
    logic [2:0]   outst_o;
    logic         err_o;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rv;
        logic        e_req;
        logic [2:0]  e_outst;
        logic        e_err;
    } vec_t;

    vec_t vt [10];

    udma_l2_rr_arbiter #(
        .N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTST(4)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .l2_req_o(l2_req_o), .l2_wen_o(l2_wen_o), .l2_addr_o(l2_addr_o),
        .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o),
        .l2_gnt_i(l2_gnt), .l2_rvalid_i(l2_rv), .l2_rdata_i(l2_rdata),
        .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic g, input logic v, input logic [31:0] d);
        req = r; l2_gnt = g; l2_rv = v; l2_rdata = d;
        #2;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_in(4'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        rst = 1'b1;
        wen = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            addr[i*32 +: 32]  = 32'h1000 + 32'(i) * 32'h100;
            wdata[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
            be[i*4 +: 4]      = 4'(i + 1);
        end

        //            req    gnt   rv    rdata         e_gnt    e_rv     e_req e_outst e_err
        vt[0] = '{4'hF, 1'b1, 1'b0, 32'h0,        4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0};
        vt[1] = '{4'hF, 1'b1, 1'b0, 32'h0,        4'b0010, 4'b0000, 1'b1, 3'd1, 1'b0};
        vt[2] = '{4'hF, 1'b1, 1'b1, 32'hD0000000, 4'b0100, 4'b0001, 1'b1, 3'd2, 1'b0};
        vt[3] = '{4'hF, 1'b1, 1'b1, 32'hD0000001, 4'b1000, 4'b0010, 1'b1, 3'd2, 1'b0};
        vt[4] = '{4'hF, 1'b1, 1'b1, 32'hD0000002, 4'b0001, 4'b0100, 1'b1, 3'd2, 1'b0};
        vt[5] = '{4'hF, 1'b1, 1'b1, 32'hD0000003, 4'b0010, 4'b1000, 1'b1, 3'd2, 1'b0};
        vt[6] = '{4'hF, 1'b1, 1'b1, 32'hD0000004, 4'b0100, 4'b0001, 1'b1, 3'd2, 1'b0};
        vt[7] = '{4'hF, 1'b1, 1'b1, 32'hD0000005, 4'b1000, 4'b0010, 1'b1, 3'd2, 1'b0};
        vt[8] = '{4'h0, 1'b0, 1'b1, 32'hD0000006, 4'b0000, 4'b0100, 1'b0, 3'd2, 1'b0};
        vt[9] = '{4'h0, 1'b0, 1'b1, 32'hD0000007, 4'b0000, 4'b1000, 1'b0, 3'd1, 1'b0};

        // Outputs held at zero during reset even with live inputs
        set_in(4'hF, 1'b1, 1'b1, 32'h12345678);
        chk("rst_l2_req", l2_req_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_outst", outst_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness table
        for (int k = 0; k < 10; k++) begin
            set_in(vt[k].req, vt[k].gnt, vt[k].rv, vt[k].rdata);
            chk($sformatf("fair%0d_gnt", k), gnt_o, vt[k].e_gnt);
            chk($sformatf("fair%0d_rvalid", k), rvalid_o, vt[k].e_rv);
            chk($sformatf("fair%0d_l2_req", k), l2_req_o, vt[k].e_req);
            chk($sformatf("fair%0d_outst", k), outst_o, vt[k].e_outst);
            chk($sformatf("fair%0d_err", k), err_o, vt[k].e_err);
            if (vt[k].e_rv != 0) chk($sformatf("fair%0d_rdata", k), rdata_o, vt[k].rdata);
            if (vt[k].e_gnt != 0) begin
                exp_addr = 32'h0;
                for (int i = 0; i < 4; i++)
                    if (vt[k].e_gnt[i]) exp_addr = 32'h1000 + 32'(i) * 32'h100;
                chk($sformatf("fair%0d_addr", k), l2_addr_o, exp_addr);
            end
            nxt();
        end

        // Lock: ptr moved to 1, requester 2 waits, requester 1 arrives later
        do_reset();
        set_in(4'b0001, 1'b1, 1'b0, 32'h0);
        chk("lock_pre_gnt", gnt_o, 4'b0001);
        nxt();
        set_in(4'b0100, 1'b0, 1'b0, 32'h0);
        chk("lock_c1_req", l2_req_o, 1);
        chk("lock_c1_addr", l2_addr_o, 32'h1200);
        chk("lock_c1_gnt", gnt_o, 0);
        nxt();
        set_in(4'b0110, 1'b0, 1'b0, 32'h0);
        chk("lock_c2_addr", l2_addr_o, 32'h1200);
        chk("lock_c2_wen", l2_wen_o, 0);
        chk("lock_c2_wdata", l2_wdata_o, 32'hCAFE0002);
        chk("lock_c2_be", l2_be_o, 4'h3);
        chk("lock_c2_gnt", gnt_o, 0);
        nxt();
        set_in(4'b0110, 1'b0, 1'b0, 32'h0);
        chk("lock_c3_addr", l2_addr_o, 32'h1200);
        nxt();
        set_in(4'b0110, 1'b1, 1'b0, 32'h0);
        chk("lock_gnt", gnt_o, 4'b0100);
        chk("lock_gnt_addr", l2_addr_o, 32'h1200);
        nxt();
        set_in(4'b0010, 1'b1, 1'b0, 32'h0);
        chk("after_lock_gnt", gnt_o, 4'b0010);
        chk("after_lock_wen", l2_wen_o, 1);
        nxt();

        // Full: fourth grant, then requests blocked until a pop
        set_in(4'b0001, 1'b1, 1'b0, 32'h0);
        chk("full_g4_gnt", gnt_o, 4'b0001);
        chk("full_g4_outst", outst_o, 3);
        nxt();
        set_in(4'b1111, 1'b1, 1'b0, 32'h0);
        chk("full_outst", outst_o, 4);
        chk("full_l2_req", l2_req_o, 0);
        chk("full_gnt", gnt_o, 0);
        nxt();
        set_in(4'b1111, 1'b1, 1'b1, 32'hBEEF0001);
        chk("full_pop_l2_req", l2_req_o, 0);
        chk("full_pop_rvalid", rvalid_o, 4'b0001);
        chk("full_pop_rdata", rdata_o, 32'hBEEF0001);
        nxt();
        set_in(4'b1111, 1'b1, 1'b0, 32'h0);
        chk("full_resume_req", l2_req_o, 1);
        chk("full_resume_gnt", gnt_o, 4'b0010);
        chk("full_resume_outst", outst_o, 3);
        nxt();

        // Drain two, then simultaneous push and pop at cnt = 2
        set_in(4'b0, 1'b0, 1'b1, 32'hA1);
        chk("drain1_rvalid", rvalid_o, 4'b0100);
        chk("drain1_outst", outst_o, 4);
        nxt();
        set_in(4'b0, 1'b0, 1'b1, 32'hA2);
        chk("drain2_rvalid", rvalid_o, 4'b0010);
        nxt();
        set_in(4'b1000, 1'b1, 1'b1, 32'hA3);
        chk("pp_gnt", gnt_o, 4'b1000);
        chk("pp_rvalid", rvalid_o, 4'b0001);
        chk("pp_outst", outst_o, 2);
        nxt();
        set_in(4'b0, 1'b0, 1'b1, 32'hA4);
        chk("pp_after_outst", outst_o, 2);
        chk("pp_after_rvalid", rvalid_o, 4'b0010);
        nxt();
        set_in(4'b0, 1'b0, 1'b1, 32'hA5);
        chk("pp_last_rvalid", rvalid_o, 4'b1000);
        chk("pp_last_rdata", rdata_o, 32'hA5);
        chk("pp_last_outst", outst_o, 1);
        nxt();

        // Spurious response
        set_in(4'b0, 1'b0, 1'b1, 32'hDEAD);
        chk("spur_err", err_o, 1);
        chk("spur_rvalid", rvalid_o, 0);
        chk("spur_outst", outst_o, 0);
        nxt();
        set_in(4'b0, 1'b0, 1'b0, 32'h0);
        chk("spur_err_end", err_o, 0);
        nxt();

        // Reset mid-flight with three outstanding
        for (int k = 0; k < 3; k++) begin
            set_in(4'b1111, 1'b1, 1'b0, 32'h0);
            chk($sformatf("rmf_gnt%0d", k), gnt_o, 4'b0001 << k);
            nxt();
        end
        set_in(4'b0, 1'b0, 1'b0, 32'h0);
        chk("rmf_outst3", outst_o, 3);
        rst = 1'b1;
        set_in(4'b1111, 1'b1, 1'b1, 32'h55);
        chk("rmf_rst_outst", outst_o, 0);
        chk("rmf_rst_req", l2_req_o, 0);
        chk("rmf_rst_rvalid", rvalid_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(4'b0, 1'b0, 1'b1, 32'h77);
            chk($sformatf("rmf_late%0d_err", k), err_o, 1);
            chk($sformatf("rmf_late%0d_rvalid", k), rvalid_o, 0);
            chk($sformatf("rmf_late%0d_outst", k), outst_o, 0);
            nxt();
            set_in(4'b0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("rmf_gap%0d_err", k), err_o, 0);
            nxt();
        end
        set_in(4'b1111, 1'b1, 1'b0, 32'h0);
        chk("rmf_ptr0_gnt", gnt_o, 4'b0001);
        nxt();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/udma_l2_rr_arbiter.md
# udma_l2_rr_arbiter

Round-robin arbiter that shares one uDMA L2 memory port (req/gnt/rvalid protocol, in-order responses) among `N_REQ` requesters, such as uDMA TX channels competing for the read-only port. It holds a locked address phase until the grant arrives and records the ID of each granted transaction in an in-order FIFO. Each response is steered back to the requester that issued it. The block sits between the uDMA channel logic and the `L2_ro_*` / `L2_wo_*` ports of the IO subsystem.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: L2 data width (`L2_DATA_WIDTH`).
- `ADDR_WIDTH`, 32: L2 address width.
- `MAX_OUTST`, 4: maximum number of granted-but-unanswered transactions; a power of 2, ≥1.
- `sys_clk_i`  in  1  single clock; all state is on its rising edge.
- `sys_rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  N_REQ  per-requester request; held high until the matching `gnt_o` bit.
- `wen_i`  in  N_REQ  per-requester write-enable, active low (L2 convention).
- `addr_i`  in  N_REQ×ADDR_WIDTH  per-requester address.
- `wdata_i`  in  N_REQ×DATA_WIDTH  per-requester write data.
- `be_i`  in  N_REQ×DATA_WIDTH/8  per-requester byte enables.
- `gnt_o`  out  N_REQ  one-hot grant.
- `rvalid_o`  out  N_REQ  one-hot response valid.
- `rdata_o`  out  DATA_WIDTH  response data, broadcast to all requesters.
- `l2_req_o`, `l2_wen_o`, `l2_addr_o`, `l2_wdata_o`, `l2_be_o`  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  downstream request.
- `l2_gnt_i`, `l2_rvalid_i`  in  1  downstream grant and response valid.
- `l2_rdata_i`  in  DATA_WIDTH  downstream response data.
- `outst_o`  out  $clog2(MAX_OUTST)+1  current outstanding count.
- `err_o`  out  1  one-cycle pulse when a response arrives with no transaction outstanding.

## Operation
- **State:**
  - round-robin pointer `ptr` (0..N_REQ-1);
  - lock flag plus locked index `lidx`;
  - ID FIFO of depth MAX_OUTST holding requester indices;
  - outstanding count `cnt`.
- **Winner selection:**
  - If lock is set, the winner is `lidx`.
  - Otherwise the winner is the first asserted `req_i` bit scanning from `ptr` upward, wrapping at N_REQ.
- **Downstream request:** `l2_req_o` = (any selected request) & (`cnt` < MAX_OUTST). The downstream request fields are muxed from the winner.
- **Grant:** `gnt_o[w]` = `l2_req_o` & `l2_gnt_i`; all other `gnt_o` bits are 0.
- **Lock:**
  - Set when `l2_req_o` = 1 and `l2_gnt_i` = 0; `lidx` is set to the winner.
  - Cleared on a grant.
  - While locked, newly arriving requests cannot preempt the winner, so the address phase stays stable.
- **On a grant:**
  - push the winner index into the ID FIFO;
  - set `ptr` to (winner+1) mod N_REQ;
  - increment `cnt`.
- **On `l2_rvalid_i`:**
  - If `cnt` > 0: pop the FIFO; `rvalid_o[head]` = 1; `rdata_o` = `l2_rdata_i`; decrement `cnt`.
  - If `cnt` = 0: drop the response; `err_o` = 1 for that cycle; no `rvalid_o` bit.
- **Grant and response in the same cycle:** push and pop both happen and `cnt` is unchanged.
- **FIFO full** (`cnt` = MAX_OUTST): `l2_req_o` is held 0 even when a response arrives in the same cycle. Requests resume in the cycle after the pop.
- **Reads and writes:** both occupy a FIFO slot. L2 returns one `rvalid` per grant, including writes.
- **Reset, at assertion:** `ptr` = 0, lock = 0, FIFO empty, `cnt` = 0.
- **Reset, output values:** while `sys_rst_i` is high, all outputs are driven 0.
- **Reset mid-operation:** outstanding IDs are discarded. Late responses after reset release produce `err_o` pulses and are not forwarded.

## Timing
- Grant path is combinational: `l2_gnt_i` → `gnt_o` has zero cycles of latency.
- Response path is combinational: `l2_rvalid_i` / `l2_rdata_i` → `rvalid_o` / `rdata_o` has zero cycles of latency.
- State updates take effect on the next rising edge. A requester that is granted in cycle t is already lowest priority for the arbitration in cycle t+1.
- Back-to-back grants, one per cycle, are sustained while `cnt` < MAX_OUTST.
- `err_o` is combinational (`l2_rvalid_i` & `cnt` = 0) and lasts exactly one cycle per spurious response.
- No combinational path from `req_i` to `l2_gnt_i` is assumed. The downstream slave may grant in the same cycle as the request.

## Test plan
- **Fairness:** all 4 requesters are held high and `l2_gnt_i` = 1 for 8 cycles.
  - Required: grants in order 0,1,2,3,0,1,2,3.
  - Required: responses returned 2 cycles later reach `rvalid_o` in the same order, with `rdata_o` matching.
- **Lock:** requester 2 requests with `l2_gnt_i` = 0 for 3 cycles, and requester 1 (higher priority from `ptr` = 1) rises in cycle 2.
  - Required: `l2_addr_o` stays at requester 2's address.
  - Required: `gnt_o` = 4'b0100 when `l2_gnt_i` rises.
- **Full:** MAX_OUTST = 4, 4 grants issued with no response.
  - Required: `outst_o` = 4 and `l2_req_o` = 0.
  - Apply one `l2_rvalid_i` → `l2_req_o` = 1 in the next cycle.
- **Simultaneous push and pop:** `cnt` = 2, grant and `rvalid` in the same cycle.
  - Required: `outst_o` stays 2.
  - Required: the FIFO head is routed correctly.
- **Spurious response:** `l2_rvalid_i` = 1 with `cnt` = 0.
  - Required: `err_o` pulses 1 cycle and `rvalid_o` = 0.
- **Reset mid-flight:** 3 transactions outstanding, then `sys_rst_i` is pulsed.
  - Required: `outst_o` = 0 and `ptr` = 0.
  - Required: 3 subsequent responses each pulse `err_o` and none is forwarded.
